// File: rtl/pv_array_seq_if.sv
// Signal bundle between the PV array sequencer, its frame controller, and the shared PV evaluation core.
// "slave" is the sequencer's view; "master" is the view of the surrounding system.
interface pv_array_seq_if #(
    parameter int NCH = 4,
    parameter int W   = 32
);
    logic             sta;
    logic [NCH-1:0]   chan_en;
    logic [NCH*W-1:0] S_bus;
    logic [NCH*W-1:0] T_bus;
    logic [NCH*W-1:0] Vd_bus;
    logic             err_clr;
    logic             core_sta;
    logic [W-1:0]     core_S;
    logic [W-1:0]     core_T;
    logic [W-1:0]     core_Vd;
    logic [W-1:0]     core_Iph;
    logic [W-1:0]     core_Id;
    logic             core_done_iph;
    logic             core_done_id;
    logic [NCH*W-1:0] Iph_bus;
    logic [NCH*W-1:0] Id_bus;
    logic             done_sig;
    logic             busy;
    logic             err_overrun;
    logic             err_timeout;

    modport slave (
        input  sta, chan_en, S_bus, T_bus, Vd_bus, err_clr,
        input  core_Iph, core_Id, core_done_iph, core_done_id,
        output core_sta, core_S, core_T, core_Vd,
        output Iph_bus, Id_bus, done_sig, busy, err_overrun, err_timeout
    );

    modport master (
        output sta, chan_en, S_bus, T_bus, Vd_bus, err_clr,
        output core_Iph, core_Id, core_done_iph, core_done_id,
        input  core_sta, core_S, core_T, core_Vd,
        input  Iph_bus, Id_bus, done_sig, busy, err_overrun, err_timeout
    );
endinterface

// File: rtl/pv_array_seq.sv
// Time-multiplexes NCH PV strings through one shared Iph/Id evaluation core and
// publishes all channel results atomically once per frame.
module pv_array_seq #(
    parameter int NCH     = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    pv_array_seq_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [CHW-1:0] r_ch;
    logic [NCH-1:0] r_en;
    logic [WDW-1:0] r_wd;
    logic           r_got_iph;
    logic           r_got_id;
    logic           r_core_sta;
    logic           r_done;
    logic           r_busy;
    logic           r_err_ovr;
    logic           r_err_to;

    logic [W-1:0]   r_sh_S    [NCH];
    logic [W-1:0]   r_sh_T    [NCH];
    logic [W-1:0]   r_sh_Vd   [NCH];
    logic [W-1:0]   r_work_iph[NCH];
    logic [W-1:0]   r_work_id [NCH];
    logic [W-1:0]   r_iph_bus [NCH];
    logic [W-1:0]   r_id_bus  [NCH];

    logic [W-1:0]   w_S [NCH];
    logic [W-1:0]   w_T [NCH];
    logic [W-1:0]   w_Vd[NCH];

    logic [CHW-1:0] w_first_ch;
    logic           w_first_vld;
    logic [CHW-1:0] w_next_ch;
    logic           w_next_vld;
    logic           w_got_iph;
    logic           w_got_id;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_S[gi]                    = bus.S_bus[gi*W +: W];
        assign w_T[gi]                    = bus.T_bus[gi*W +: W];
        assign w_Vd[gi]                   = bus.Vd_bus[gi*W +: W];
        assign bus.Iph_bus[gi*W +: W]     = r_iph_bus[gi];
        assign bus.Id_bus[gi*W +: W]      = r_id_bus[gi];
    end

    // Lowest enabled channel from the live mask (frame start) and the next
    // enabled channel above ch from the frame's latched mask.
    always_comb begin
        w_first_ch  = '0;
        w_first_vld = 1'b0;
        w_next_ch   = '0;
        w_next_vld  = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.chan_en[k]) begin
                w_first_ch  = CHW'(k);
                w_first_vld = 1'b1;
            end
            if (r_en[k] && (k > int'(r_ch))) begin
                w_next_ch  = CHW'(k);
                w_next_vld = 1'b1;
            end
        end
    end

    assign w_got_iph = r_got_iph | bus.core_done_iph;
    assign w_got_id  = r_got_id  | bus.core_done_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_en       <= '0;
            r_wd       <= '0;
            r_got_iph  <= 1'b0;
            r_got_id   <= 1'b0;
            r_core_sta <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err_ovr  <= 1'b0;
            r_err_to   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_sh_S[k]     <= '0;
                r_sh_T[k]     <= '0;
                r_sh_Vd[k]    <= '0;
                r_work_iph[k] <= '0;
                r_work_id[k]  <= '0;
                r_iph_bus[k]  <= '0;
                r_id_bus[k]   <= '0;
            end
        end else begin
            r_core_sta <= 1'b0;
            r_done     <= 1'b0;

            // Set events are written after the clear so they take priority.
            if (bus.err_clr) begin
                r_err_ovr <= 1'b0;
                r_err_to  <= 1'b0;
            end
            if (bus.sta && (r_state != S_IDLE))
                r_err_ovr <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.sta) begin
                        for (int k = 0; k < NCH; k++) begin
                            r_sh_S[k]     <= w_S[k];
                            r_sh_T[k]     <= w_T[k];
                            r_sh_Vd[k]    <= w_Vd[k];
                            r_work_iph[k] <= r_iph_bus[k];
                            r_work_id[k]  <= r_id_bus[k];
                        end
                        r_en      <= bus.chan_en;
                        r_busy    <= 1'b1;
                        r_got_iph <= 1'b0;
                        r_got_id  <= 1'b0;
                        if (w_first_vld) begin
                            r_ch       <= w_first_ch;
                            r_wd       <= '0;
                            r_core_sta <= 1'b1;
                            r_state    <= S_LAUNCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_LAUNCH: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (bus.core_done_iph && !r_got_iph) begin
                        r_got_iph        <= 1'b1;
                        r_work_iph[r_ch] <= bus.core_Iph;
                    end
                    if (bus.core_done_id && !r_got_id) begin
                        r_got_id        <= 1'b1;
                        r_work_id[r_ch] <= bus.core_Id;
                    end
                    if (w_got_iph && w_got_id) begin
                        r_state <= S_STORE;
                    end else if ((TIMEOUT != 0) && (r_wd == WD_LAST)) begin
                        // A stalled core must not leave half a result behind: put back the frame-start value.
                        r_err_to         <= 1'b1;
                        r_work_iph[r_ch] <= r_iph_bus[r_ch];
                        r_work_id[r_ch]  <= r_id_bus[r_ch];
                        r_state          <= S_STORE;
                    end
                end

                S_STORE: begin
                    r_got_iph <= 1'b0;
                    r_got_id  <= 1'b0;
                    r_wd      <= '0;
                    if (w_next_vld) begin
                        r_ch       <= w_next_ch;
                        r_core_sta <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end else begin
                        r_iph_bus <= r_work_iph;
                        r_id_bus  <= r_work_id;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_sta    = r_core_sta;
    assign bus.core_S      = r_sh_S[r_ch];
    assign bus.core_T      = r_sh_T[r_ch];
    assign bus.core_Vd     = r_sh_Vd[r_ch];
    assign bus.done_sig    = r_done;
    assign bus.busy        = r_busy;
    assign bus.err_overrun = r_err_ovr;
    assign bus.err_timeout = r_err_to;
endmodule

// File: tb/tb_pv_array_seq.sv
// Randomized frame-level bench for pv_array_seq with a behavioural core model and
// a per-frame reference computed from the channel mask and core latencies.
module tb_pv_array_seq;
    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pv_array_seq_if #(.NCH(NCH), .W(W)) bus ();

    pv_array_seq #(.NCH(NCH), .W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_iph[NCH];
    logic [31:0] exp_id [NCH];
    logic [31:0] s_val[NCH];
    logic [31:0] t_val[NCH];
    logic [31:0] v_val[NCH];

    // Core-model configuration, written by the stimulus thread only.
    int m_ord[NCH];
    int m_n    = 0;
    int m_liph = 1;
    int m_lid  = 1;
    bit m_dup  = 1'b0;
    int m_drop = -1;
    int m_base = 0;

    // Core-model state, written by the core model only.
    int launch_total = 0;
    int cur_launch   = -1;
    int since        = -1;
    logic [31:0] op_S[16];
    logic [31:0] op_T[16];
    logic [31:0] op_V[16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Core: Iph = S+1 after m_liph cycles, Id = Vd+2 after m_lid cycles, optional
    // duplicate Iph pulse carrying a wrong value, optional missing Id for one launch.
    initial begin
        bus.core_done_iph = 1'b0;
        bus.core_done_id  = 1'b0;
        bus.core_Iph      = '0;
        bus.core_Id       = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                since = -1;
            end else begin
                if (since >= 0) since++;
                if (bus.core_sta) begin
                    cur_launch = launch_total - m_base;
                    if (cur_launch >= 0 && cur_launch < 16) begin
                        op_S[cur_launch] = bus.core_S;
                        op_T[cur_launch] = bus.core_T;
                        op_V[cur_launch] = bus.core_Vd;
                    end
                    launch_total++;
                    since = 0;
                end
            end
            bus.core_done_iph = (since == m_liph) || (m_dup && since == m_liph + 2);
            bus.core_Iph      = (since == m_liph) ? bus.core_S + 32'd1 : ~(bus.core_S + 32'd1);
            bus.core_done_id  = (since == m_lid) && (cur_launch != m_drop);
            bus.core_Id       = bus.core_Vd + 32'd2;
        end
    end

    task automatic randomize_vals();
        for (int k = 0; k < NCH; k++) begin
            s_val[k] = $urandom;
            t_val[k] = $urandom;
            v_val[k] = $urandom;
        end
    endtask

    task automatic load_buses();
        for (int k = 0; k < NCH; k++) begin
            bus.S_bus[k*W +: W]  = s_val[k];
            bus.T_bus[k*W +: W]  = t_val[k];
            bus.Vd_bus[k*W +: W] = v_val[k];
        end
    endtask

    task automatic scramble_buses();
        for (int k = 0; k < NCH; k++) begin
            bus.S_bus[k*W +: W]  = $urandom;
            bus.T_bus[k*W +: W]  = $urandom;
            bus.Vd_bus[k*W +: W] = $urandom;
        end
        bus.chan_en = 4'($urandom);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    // One complete frame; ovr_at>0 pulses sta (and err_clr if ovr_clr) in that frame cycle.
    task automatic run_frame(input string name, input logic [NCH-1:0] mask, input int liph,
                             input int lid, input bit dup, input int drop_ch,
                             input int ovr_at, input bit ovr_clr, input bit chk_cyc);
        logic [31:0]      nx_iph[NCH];
        logic [31:0]      nx_id [NCH];
        logic [NCH*W-1:0] old_iph;
        logic [NCH*W-1:0] old_id;
        int exp_cyc, got_cyc, lmax;
        bit changed;
        m_n    = 0;
        m_drop = -1;
        for (int k = 0; k < NCH; k++) begin
            nx_iph[k] = exp_iph[k];
            nx_id[k]  = exp_id[k];
            old_iph[k*W +: W] = exp_iph[k];
            old_id[k*W +: W]  = exp_id[k];
            if (mask[k]) begin
                if (k == drop_ch) begin
                    m_drop = m_n;
                end else begin
                    nx_iph[k] = s_val[k] + 32'd1;
                    nx_id[k]  = v_val[k] + 32'd2;
                end
                m_ord[m_n] = k;
                m_n++;
            end
        end
        lmax    = (liph > lid) ? liph : lid;
        exp_cyc = (m_n == 0) ? 1 : m_n * (lmax + 2) + 1;
        m_liph  = liph;
        m_lid   = lid;
        m_dup   = dup;
        m_base  = launch_total;

        @(negedge clk);
        load_buses();
        bus.chan_en = mask;
        bus.sta     = 1'b1;
        got_cyc = -1;
        changed = 1'b0;
        for (int rel = 1; rel <= 3000 && got_cyc < 0; rel++) begin
            @(negedge clk);
            bus.sta     = (rel == ovr_at);
            bus.err_clr = ovr_clr && (rel == ovr_at);
            if (rel == 1) scramble_buses();
            if (bus.done_sig) got_cyc = rel;
            else if (bus.Iph_bus !== old_iph || bus.Id_bus !== old_id) changed = 1'b1;
        end
        bus.sta     = 1'b0;
        bus.err_clr = 1'b0;

        if (chk_cyc) chk({name, " done_cycle"}, got_cyc, exp_cyc);
        else         chk({name, " done_seen"}, 32'(got_cyc > 0), 32'd1);
        chk({name, " busy_in_done"}, 32'(bus.busy), 32'd1);
        chk({name, " launches"}, launch_total - m_base, m_n);
        chk({name, " bus_stable"}, 32'(changed), 32'd0);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s iph[%0d]", name, k), bus.Iph_bus[k*W +: W], nx_iph[k]);
            chk($sformatf("%s id[%0d]", name, k), bus.Id_bus[k*W +: W], nx_id[k]);
            exp_iph[k] = nx_iph[k];
            exp_id[k]  = nx_id[k];
        end
        for (int i = 0; i < m_n; i++) begin
            chk($sformatf("%s core_S#%0d", name, i), op_S[i], s_val[m_ord[i]]);
            chk($sformatf("%s core_T#%0d", name, i), op_T[i], t_val[m_ord[i]]);
            chk($sformatf("%s core_Vd#%0d", name, i), op_V[i], v_val[m_ord[i]]);
        end
        @(negedge clk);
        chk({name, " done_pulse_end"}, 32'(bus.done_sig), 32'd0);
        chk({name, " busy_end"}, 32'(bus.busy), 32'd0);
        $display("frame %s mask=%b liph=%0d lid=%0d done_cycle=%0d", name, mask, liph, lid, got_cyc);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        rst         = 1'b0;
        bus.sta     = 1'b0;
        bus.err_clr = 1'b0;
        bus.chan_en = '0;
        bus.S_bus   = '0;
        bus.T_bus   = '0;
        bus.Vd_bus  = '0;
        for (int k = 0; k < NCH; k++) begin
            exp_iph[k] = '0;
            exp_id[k]  = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done_sig", 32'(bus.done_sig), 32'd0);
        chk("reset core_sta", 32'(bus.core_sta), 32'd0);
        chk("reset err_overrun", 32'(bus.err_overrun), 32'd0);
        chk("reset err_timeout", 32'(bus.err_timeout), 32'd0);
        chk("reset core_S", bus.core_S, 32'd0);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("reset iph[%0d]", k), bus.Iph_bus[k*W +: W], 32'd0);
            chk($sformatf("reset id[%0d]", k), bus.Id_bus[k*W +: W], 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        randomize_vals();
        s_val[0] = 32'd10; s_val[1] = 32'd20; s_val[2] = 32'd30; s_val[3] = 32'd40;
        v_val[0] = 32'd1;  v_val[1] = 32'd2;  v_val[2] = 32'd3;  v_val[3] = 32'd4;
        run_frame("full", 4'hF, 5, 9, 1'b0, -1, 0, 1'b0, 1'b1);
        chk("full err_overrun", 32'(bus.err_overrun), 32'd0);
        chk("full err_timeout", 32'(bus.err_timeout), 32'd0);

        randomize_vals();
        s_val[0] = 32'd100; s_val[1] = 32'd200; s_val[2] = 32'd300; s_val[3] = 32'd400;
        run_frame("partial", 4'b0101, 5, 9, 1'b0, -1, 0, 1'b0, 1'b1);

        randomize_vals();
        run_frame("zero_mask", 4'b0000, 5, 9, 1'b0, -1, 0, 1'b0, 1'b1);

        randomize_vals();
        run_frame("overrun", 4'hF, 5, 9, 1'b0, -1, 5, 1'b0, 1'b1);
        chk("overrun flag_set", 32'(bus.err_overrun), 32'd1);
        pulse_clr();
        chk("overrun flag_cleared", 32'(bus.err_overrun), 32'd0);

        randomize_vals();
        run_frame("ovr_vs_clr", 4'b0011, 5, 9, 1'b0, -1, 4, 1'b1, 1'b1);
        chk("ovr_vs_clr set_wins", 32'(bus.err_overrun), 32'd1);
        pulse_clr();

        randomize_vals();
        run_frame("coincident", 4'hF, 7, 7, 1'b1, -1, 0, 1'b0, 1'b1);

        randomize_vals();
        run_frame("dup_in_wait", 4'hF, 3, 9, 1'b1, -1, 0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            randomize_vals();
            run_frame($sformatf("rand%0d", r), 4'($urandom_range(15)),
                      int'($urandom_range(10, 1)), int'($urandom_range(10, 1)),
                      1'($urandom_range(1)), -1, 0, 1'b0, 1'b1);
        end
        chk("rand err_timeout", 32'(bus.err_timeout), 32'd0);

        randomize_vals();
        run_frame("timeout", 4'hF, 5, 9, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("timeout flag_set", 32'(bus.err_timeout), 32'd1);
        pulse_clr();
        chk("timeout flag_cleared", 32'(bus.err_timeout), 32'd0);

        // Reset asserted while channel 2 is in WAIT (its launch is frame cycle 23).
        randomize_vals();
        m_liph = 5; m_lid = 9; m_dup = 1'b0; m_drop = -1; m_base = launch_total;
        @(negedge clk);
        load_buses();
        bus.chan_en = 4'hF;
        bus.sta     = 1'b1;
        saw_done    = 1'b0;
        for (int rel = 1; rel <= 26; rel++) begin
            @(negedge clk);
            bus.sta = 1'b0;
            if (bus.done_sig) saw_done = 1'b1;
        end
        rst = 1'b0;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done_sig", 32'(bus.done_sig), 32'd0);
        chk("midrst core_sta", 32'(bus.core_sta), 32'd0);
        chk("midrst core_S", bus.core_S, 32'd0);
        chk("midrst core_Vd", bus.core_Vd, 32'd0);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("midrst iph[%0d]", k), bus.Iph_bus[k*W +: W], 32'd0);
            chk($sformatf("midrst id[%0d]", k), bus.Id_bus[k*W +: W], 32'd0);
            exp_iph[k] = '0;
            exp_id[k]  = '0;
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done_sig) saw_done = 1'b1;
        end
        chk("midrst no_done", 32'(saw_done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        randomize_vals();
        run_frame("after_reset", 4'b1011, 4, 6, 1'b0, -1, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pv_array_seq.md
# pv_array_seq

Multi-channel PV array sequencer. It time-multiplexes NCH PV strings through a single shared PV evaluation core: the single-channel Iph/Id compute chain with a start pulse and separate Iph and Id done pulses. Per frame it snapshots all channel inputs, evaluates every enabled channel in ascending order, and publishes all Iph/Id results atomically with one done pulse. It adds per-channel enable, a watchdog timeout and sticky error flags, which the single-channel PV block does not have. It sits between the AD/FIFO front end and the network solver.

## Interface
Parameters:
- NCH, 4: number of PV channels (1..16).
- W, 32: data width, IEEE-754 single (`SINGLE).
- TIMEOUT, 1024: maximum cycles spent in WAIT per channel; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- sta  in  1  frame start pulse.
- chan_en  in  NCH  channel enable mask, sampled with sta.
- S_bus, T_bus, Vd_bus  in  NCH*W each  per-channel irradiance, temperature and diode voltage; channel k occupies bits [k*W +: W].
- err_clr  in  1  clears the sticky error flags.
- core_sta  out  1  one-cycle start pulse to the shared core.
- core_S, core_T, core_Vd  out  W each  operands for the current channel.
- core_Iph, core_Id  in  W each  core results.
- core_done_iph, core_done_id  in  1 each  core done pulses; they are independent and may coincide.
- Iph_bus, Id_bus  out  NCH*W each  published results.
- done_sig  out  1  one-cycle frame-complete pulse.
- busy  out  1  high in every state except IDLE.
- err_overrun, err_timeout  out  1 each  sticky error flags.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, STORE, DONE.
- IDLE, sta=1:
  - Latch S/T/Vd buses and chan_en into shadow registers.
  - Load the working buffer from Iph_bus/Id_bus.
  - Set ch to the lowest enabled channel and go to LAUNCH.
  - If chan_en is all zero, go directly to DONE.
- LAUNCH: core_sta=1 for exactly one cycle, then go to WAIT.
- Operand hold: core_S/T/Vd are driven from shadow[ch] from LAUNCH through STORE. Input buses may change freely after sta is accepted.
- WAIT:
  - A sampled core_done_iph sets got_iph and captures core_Iph into working[ch].
  - A sampled core_done_id sets got_id and captures core_Id into working[ch].
  - When both flags are set (either order or the same cycle), go to STORE.
  - A duplicate done pulse for an already-set flag is ignored.
- STORE: clear the flags and advance ch to the next enabled channel, then go to LAUNCH. If no enabled channel remains, copy the whole working buffer to Iph_bus/Id_bus and go to DONE.
- DONE: done_sig=1 for one cycle, then go to IDLE.
- Disabled channels keep their previous Iph_bus/Id_bus values.
- Watchdog:
  - A counter runs while in WAIT and is cleared on entering LAUNCH.
  - When it reaches TIMEOUT (TIMEOUT≠0), set err_timeout, restore working[ch] to its frame-start value (discarding any partial capture), and go to STORE.
- Error flags:
  - sta sampled in any state other than IDLE is ignored and sets err_overrun.
  - Core done pulses sampled outside WAIT are ignored.
  - err_clr=1 clears both flags. A set event in the same cycle as err_clr wins (flag stays set).
- Arithmetic: the block does no arithmetic on data. ch is $clog2(NCH) bits wide, minimum 1. The watchdog counter is $clog2(TIMEOUT+1) bits wide.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - core_sta, done_sig, busy, err_overrun and err_timeout are all 0.
  - Iph_bus, Id_bus, core_S, core_T, core_Vd and the working buffer are all 0.
  - Assertion mid-frame aborts the frame immediately; no done_sig is issued.
- Cycle numbering: sta is accepted at edge E0. LAUNCH is cycle 1.
- Core latency L: a done pulse is high in cycle c+L when core_sta was high in cycle c.
- Per channel: LAUNCH → last done pulse at +Lmax → STORE at +Lmax+1 → next LAUNCH at +Lmax+2.
- Frame latency: with n enabled channels, done_sig is high in cycle n·(Lmax+2)+1. With n=0, done_sig is high in cycle 1.
- Iph_bus/Id_bus change only on the edge that enters DONE, so they are valid in the same cycle done_sig is high. Outputs are never partially updated.
- busy rises after E0 and falls after the DONE cycle. sta may be re-accepted in the cycle after DONE.

## Test plan
All scenarios use NCH=4, W=32 and a core model where Iph=S+1 after 5 cycles and Id=Vd+2 after 9 cycles.
- Reset then full frame: chan_en=4'hF, S=10,20,30,40, Vd=1,2,3,4 → done_sig in cycle 45; Iph_bus=11,21,31,41; Id_bus=3,4,5,6; exactly 4 core_sta pulses.
- Partial mask: after the first frame, chan_en=4'b0101 with new S=100,200,300,400 → done_sig in cycle 23; Iph ch0=101, ch2=301; ch1 and ch3 unchanged.
- Zero mask and overrun: chan_en=0 → done_sig in cycle 1 with buses unchanged. sta reasserted mid-frame → err_overrun=1, frame result unaffected, err_clr clears the flag.
- Coincident done and duplicates: model with both latencies 7 plus a repeated core_done_iph → one STORE per channel; done_sig in cycle 37 for 4 channels.
- Timeout: TIMEOUT=16, model never asserts core_done_id for ch1 → err_timeout=1; ch1 keeps its previous values; other channels update; done_sig still issued.
- Reset mid-frame: rst=0 during ch2 WAIT → all outputs return to 0 immediately, no done_sig; the next frame completes normally.
